md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  EX-stage MD arithmetic instruction is valid this cycle.
REQ-006 SHALL have port md_op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-007 SHALL have port src_a  input  32  rs operand (multiplicand/dividend).
REQ-008 SHALL have port src_b  input  32  rt operand (multiplier/divisor).
REQ-009 SHALL have port hilo_wr  input  1  EX-stage MTHI/MTLO is valid this cycle.
REQ-010 SHALL have port hilo_sel  input  1  0 selects LO, 1 selects HI, for hilo_wr.
REQ-011 SHALL have port id_md_use  input  1  ID-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-012 SHALL have port busy  output  1  arithmetic operation in progress.
REQ-013 SHALL have port md_stall  output  1  freeze PC and IF/ID, bubble ID/EX.
REQ-014 SHALL have port hi  output  32  HI register.
REQ-015 SHALL have port lo  output  32  LO register.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, RUN.
REQ-017 IDLE with start=1 at edge t SHALL latch the op result, load the counter with MULT_CYCLES or DIV_CYCLES per md_op, and enter RUN.
REQ-018 busy SHALL equal 1 exactly while in RUN, i.e. N consecutive cycles starting at cycle t+1.
REQ-019 The counter SHALL decrement once per RUN cycle; the edge at which it reaches 0 SHALL write HI/LO and return to IDLE, so new HI/LO is visible in the first cycle with busy=0.
REQ-020 MULT SHALL form the signed 64-bit product {HI,LO}; MULTU the unsigned 64-bit product.
REQ-021 DIV SHALL give LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign; DIVU the unsigned quotient/remainder.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 Divisor 0 (DIV or DIVU) SHALL run the full DIV_CYCLES and leave HI and LO unchanged.
REQ-024 md_stall SHALL equal id_md_use & (start | busy), combinationally.
REQ-025 start while in RUN SHALL be ignored.
REQ-026 hilo_wr in IDLE with start=0 SHALL write src_a into HI or LO per hilo_sel at the next edge.
REQ-027 hilo_wr while in RUN SHALL be ignored.
REQ-028 start and hilo_wr both set in IDLE SHALL start the operation and ignore hilo_wr.
REQ-029 Operands SHALL be sampled only at the start edge; src_a/src_b changes during RUN SHALL NOT affect the result.

Reset
REQ-030 reset=1 at a posedge SHALL force IDLE, counter=0, hi=0, lo=0 and busy=0, including mid-operation.
REQ-031 A pending result aborted by reset SHALL never be written.
REQ-032 reset SHALL take priority over start and hilo_wr in the same cycle.
REQ-033 md_stall SHALL be 0 in the cycle after reset, unless start and id_md_use are both 1.

Structure
REQ-034 A shared package md_pkg SHALL hold the md_op encodings, the FSM state encoding and the MULT_CYCLES/DIV_CYCLES defaults.
REQ-035 The 64-bit arithmetic (product, quotient, remainder, divide-by-zero flag) SHALL reside in one combinational sub-module md_arith.
REQ-036 md_ctrl SHALL contain the FSM, the counter, the result latch, and the HI/LO registers.

Verification
REQ-037 MULT with src_a=0xFFFFFFFE (-2), src_b=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 MULTU with src_a=0xFFFFFFFF, src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-039 DIV with src_a=-7, src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU by 0 -> hi and lo unchanged.
REQ-040 id_md_use=1 during start and each busy cycle -> md_stall=1 for 1+N cycles; id_md_use=0 -> md_stall=0 throughout.
REQ-041 MTLO with src_a=0x12345678 in IDLE -> lo=0x12345678 next cycle; the same MTLO during RUN -> lo unchanged.
REQ-042 reset asserted in the 3rd busy cycle of a DIV -> next cycle busy=0, hi=lo=0, and no later update occurs.

Source files
------------

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg -- shared definitions for the multiply/divide unit.
//   md_op_e     : operation encodings carried on md_op
//   md_state_e  : controller FSM state encoding
//   *_CYCLES_DEF: default busy lengths for multiply and divide
//   op_is_div   : true for DIV/DIVU
//   cnt_width   : counter width able to hold the larger busy length
// ---------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic int cnt_width(input int a, input int b);
        int mx;
        mx = (a > b) ? a : b;
        if (mx < 1) begin
            return 1;
        end
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/md_arith.sv
// ---------------------------------------------------------------------------
// md_arith -- purely combinational 64-bit multiply / 32-bit divide datapath.
// Ports:
//   i_op       : operation (md_op_e encoding)
//   i_a, i_b   : operands (multiplicand/dividend, multiplier/divisor)
//   o_hi, o_lo : result halves (product high/low, or remainder/quotient)
//   o_div_zero : divide operation with a zero divisor (result must be dropped)
// ---------------------------------------------------------------------------
module md_arith
    import md_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero
);

    md_op_e      w_op;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;
    logic        w_div_zero;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Signed and unsigned forms share one unsigned core: operate on
    // magnitudes and re-apply the sign afterwards. This also sidesteps the
    // -2^31 / -1 overflow case, whose magnitude quotient 2^31 negates back to
    // 0x80000000 with a zero remainder.
    always_comb begin
        w_op       = md_op_e'(i_op);
        w_signed   = (w_op == MD_MULT) || (w_op == MD_DIV);
        w_a_neg    = w_signed & i_a[31];
        w_b_neg    = w_signed & i_b[31];
        w_a_mag    = w_a_neg ? (32'd0 - i_a) : i_a;
        w_b_mag    = w_b_neg ? (32'd0 - i_b) : i_b;

        w_prod_mag = {32'd0, w_a_mag} * {32'd0, w_b_mag};
        w_prod     = (w_a_neg ^ w_b_neg) ? (64'd0 - w_prod_mag) : w_prod_mag;

        // A zero divisor is replaced by 1 only to keep the divider defined;
        // its result is discarded by the controller.
        w_div_zero = (i_b == 32'd0);
        w_divisor  = w_div_zero ? 32'd1 : w_b_mag;
        w_q_mag    = w_a_mag / w_divisor;
        w_r_mag    = w_a_mag % w_divisor;
        w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

        if (op_is_div(w_op)) begin
            o_hi       = w_rem;
            o_lo       = w_quot;
            o_div_zero = w_div_zero;
        end else begin
            o_hi       = w_prod[63:32];
            o_lo       = w_prod[31:0];
            o_div_zero = 1'b0;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// ---------------------------------------------------------------------------
// md_ctrl -- multi-cycle MULT/MULTU/DIV/DIVU controller with HI/LO registers.
// The result is computed and captured at the start edge; a down-counter then
// models the unit's latency and HI/LO are committed when it expires.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, md_op      : launch an arithmetic op (ignored while busy)
//   src_a, src_b      : operands, sampled only at the start edge
//   hilo_wr, hilo_sel : MTHI/MTLO write of src_a (1=HI, 0=LO), idle only
//   id_md_use         : ID-stage instruction touches the MD unit
//   busy              : operation in progress
//   md_stall          : pipeline hold request
//   hi, lo            : architectural HI/LO
// ---------------------------------------------------------------------------
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_wr,
    input  logic        hilo_sel,
    input  logic        id_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e   r_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_res_wr;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    md_state_e   w_state_next;
    logic [CNT_W-1:0] w_count_next;
    logic [31:0] w_res_hi_next;
    logic [31:0] w_res_lo_next;
    logic        w_res_wr_next;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;

    logic [31:0] w_arith_hi;
    logic [31:0] w_arith_lo;
    logic        w_arith_div_zero;
    logic        w_busy;

    md_arith u_arith (
        .i_op       (md_op),
        .i_a        (src_a),
        .i_b        (src_b),
        .o_hi       (w_arith_hi),
        .o_lo       (w_arith_lo),
        .o_div_zero (w_arith_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // Clearing r_res_wr drops any result still in flight.
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_wr <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_res_hi <= w_res_hi_next;
            r_res_lo <= w_res_lo_next;
            r_res_wr <= w_res_wr_next;
            r_hi     <= w_hi_next;
            r_lo     <= w_lo_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_res_hi_next = r_res_hi;
        w_res_lo_next = r_res_lo;
        w_res_wr_next = r_res_wr;
        w_hi_next     = r_hi;
        w_lo_next     = r_lo;

        case (r_state)
            ST_IDLE: begin
                // start wins over a simultaneous MTHI/MTLO.
                if (start) begin
                    w_res_hi_next = w_arith_hi;
                    w_res_lo_next = w_arith_lo;
                    w_res_wr_next = ~w_arith_div_zero;
                    w_count_next  = op_is_div(md_op_e'(md_op)) ? CNT_W'(DIV_CYCLES)
                                                               : CNT_W'(MULT_CYCLES);
                    w_state_next  = ST_RUN;
                end else if (hilo_wr) begin
                    if (hilo_sel) begin
                        w_hi_next = src_a;
                    end else begin
                        w_lo_next = src_a;
                    end
                end
            end
            ST_RUN: begin
                // Last RUN cycle: the edge that brings the count to zero
                // commits the result, so it is visible as busy drops.
                if (r_count <= CNT_W'(1)) begin
                    w_count_next  = '0;
                    w_state_next  = ST_IDLE;
                    w_res_wr_next = 1'b0;
                    if (r_res_wr) begin
                        w_hi_next = r_res_hi;
                        w_lo_next = r_res_lo;
                    end
                end else begin
                    w_count_next = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    assign w_busy   = (r_state == ST_RUN);
    assign busy     = w_busy;
    assign md_stall = id_md_use & (start | w_busy);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_wr;
    logic        hilo_sel;
    logic        id_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .hilo_wr   (hilo_wr),
        .hilo_sel  (hilo_sel),
        .id_md_use (id_md_use),
        .busy      (busy),
        .md_stall  (md_stall),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op, scramble operands during RUN, and count busy / stall
    // cycles until busy drops (bounded).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_id, output int busy_n, output int stall_n);
        md_op = op; src_a = a; src_b = b; id_md_use = use_id; start = 1'b1;
        #1;
        stall_n = (md_stall === 1'b1) ? 1 : 0;
        tick();
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        busy_n = 0;
        while (busy === 1'b1 && busy_n < 40) begin
            if (md_stall === 1'b1) stall_n++;
            busy_n++;
            tick();
        end
        id_md_use = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; hilo_wr = 1'b0; hilo_sel = 1'b0;
        md_op = 2'd0; src_a = '0; src_b = '0; id_md_use = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h want=00000000", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h want=00000000", lo); end
        n_tests++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b want=0", md_stall); end
        start = 1'b1;
        #1;
        n_tests++; if (md_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_start got=%b want=1", md_stall); end
        start = 1'b0; id_md_use = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after got=%b want=0", busy); end
        $display("[TB] reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_mult();
        int bn, sn;
        do_op(2'd0, 32'hFFFFFFFE, 32'd3, 1'b1, bn, sn);
        n_tests++; if (bn != 5) begin n_fail++; $display("FAIL mult_busy got=%0d want=5", bn); end
        n_tests++; if (sn != 6) begin n_fail++; $display("FAIL mult_stall got=%0d want=6", sn); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
        n_tests++; if (lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo got=%h want=fffffffa", lo); end
        $display("[TB] MULT -2*3: busy=%0d stall=%0d hi=%h lo=%h", bn, sn, hi, lo);
    endtask

    task automatic test_multu();
        int bn, sn;
        do_op(2'd1, 32'hFFFFFFFF, 32'd2, 1'b0, bn, sn);
        n_tests++; if (bn != 5) begin n_fail++; $display("FAIL multu_busy got=%0d want=5", bn); end
        n_tests++; if (sn != 0) begin n_fail++; $display("FAIL multu_stall got=%0d want=0", sn); end
        n_tests++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL multu_hi got=%h want=00000001", hi); end
        n_tests++; if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
        $display("[TB] MULTU ffffffff*2: busy=%0d hi=%h lo=%h", bn, hi, lo);
    endtask

    task automatic test_div();
        int bn, sn;
        do_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b1, bn, sn);
        n_tests++; if (bn != 10) begin n_fail++; $display("FAIL div_busy got=%0d want=10", bn); end
        n_tests++; if (sn != 11) begin n_fail++; $display("FAIL div_stall got=%0d want=11", sn); end
        n_tests++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
        $display("[TB] DIV -7/2: busy=%0d hi=%h lo=%h", bn, hi, lo);
    endtask

    task automatic test_divu_zero();
        int bn, sn;
        do_op(2'd3, 32'd5, 32'd0, 1'b0, bn, sn);
        n_tests++; if (bn != 10) begin n_fail++; $display("FAIL divz_busy got=%0d want=10", bn); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_hi got=%h want=ffffffff", hi); end
        n_tests++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL divz_lo got=%h want=fffffffd", lo); end
        $display("[TB] DIVU 5/0: busy=%0d hi=%h lo=%h", bn, hi, lo);
    endtask

    task automatic test_div_overflow();
        int bn, sn;
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, bn, sn);
        n_tests++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo got=%h want=80000000", lo); end
        n_tests++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL divovf_hi got=%h want=00000000", hi); end
        $display("[TB] DIV 80000000/ffffffff: busy=%0d hi=%h lo=%h", bn, hi, lo);
        do_op(2'd3, 32'd100, 32'd7, 1'b0, bn, sn);
        n_tests++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got=%h want=0000000e", lo); end
        n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got=%h want=00000002", hi); end
        $display("[TB] DIVU 100/7: busy=%0d hi=%h lo=%h", bn, hi, lo);
    endtask

    task automatic test_mthilo();
        hilo_wr = 1'b1; hilo_sel = 1'b0; src_a = 32'h12345678;
        tick();
        n_tests++; if (lo !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_lo got=%h want=12345678", lo); end
        n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL mtlo_hi got=%h want=00000002", hi); end
        hilo_sel = 1'b1; src_a = 32'hAABBCCDD;
        tick();
        hilo_wr = 1'b0;
        n_tests++; if (hi !== 32'hAABBCCDD) begin n_fail++; $display("FAIL mthi_hi got=%h want=aabbccdd", hi); end
        n_tests++; if (lo !== 32'h12345678) begin n_fail++; $display("FAIL mthi_lo got=%h want=12345678", lo); end
        $display("[TB] MTLO/MTHI: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mtlo_run();
        int n;
        md_op = 2'd0; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        hilo_wr = 1'b1; hilo_sel = 1'b0; src_a = 32'hDEADBEEF;
        tick();
        n_tests++; if (lo !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_run_lo got=%h want=12345678", lo); end
        hilo_sel = 1'b1;
        tick();
        hilo_wr = 1'b0;
        n_tests++; if (hi !== 32'hAABBCCDD) begin n_fail++; $display("FAIL mthi_run_hi got=%h want=aabbccdd", hi); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        n_tests++; if (lo !== 32'd6) begin n_fail++; $display("FAIL mtlo_run_res_lo got=%h want=00000006", lo); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mtlo_run_res_hi got=%h want=00000000", hi); end
        $display("[TB] MTLO during MULT 2*3: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        int n;
        md_op = 2'd1; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
        hilo_wr = 1'b1; hilo_sel = 1'b0;
        tick();
        start = 1'b0; hilo_wr = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b want=1", busy); end
        n_tests++; if (lo !== 32'd6) begin n_fail++; $display("FAIL b2b_hilo_ignored got=%h want=00000006", lo); end
        tick();
        start = 1'b1; md_op = 2'd2; src_a = 32'd100; src_b = 32'd7;
        tick();
        start = 1'b0;
        n = 2;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        n_tests++; if (n != 5) begin n_fail++; $display("FAIL b2b_len got=%0d want=5", n); end
        n_tests++; if (lo !== 32'd42) begin n_fail++; $display("FAIL b2b_lo got=%h want=0000002a", lo); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL b2b_hi got=%h want=00000000", hi); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_restart got=%b want=0", busy); end
        $display("[TB] MULTU 7*6 with ignored start in RUN: len=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    task automatic test_reset_mid();
        md_op = 2'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1; start = 1'b1; hilo_wr = 1'b1; hilo_sel = 1'b0; src_a = 32'h55;
        tick();
        reset = 1'b0; start = 1'b0; hilo_wr = 1'b0; id_md_use = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b want=0", busy); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rmid_hi got=%h want=00000000", hi); end
        n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rmid_lo got=%h want=00000000", lo); end
        n_tests++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall got=%b want=0", md_stall); end
        id_md_use = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_tests++; if (lo !== 32'd0 || hi !== 32'd0) begin n_fail++; $display("FAIL rmid_late got=%h_%h want=00000000_00000000", hi, lo); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_late_busy got=%b want=0", busy); end
        $display("[TB] reset in DIVU busy cycle 3: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_div_overflow();
        test_mthilo();
        test_mtlo_run();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
